// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory port and mem_responder.
// The master drives the request side; the slave returns the registered response.
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack,
        input  err,
        input  busy
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack,
        output err,
        output busy
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder: captures a request, waits WAIT_CYCLES,
// commits the access on the edge entering RESP and pulses a registered ack/err.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic        HAS_WAIT  = (WAIT_CYCLES > 0) ? 1'b1 : 1'b0;

    // Misaligned byte address or any bit above the word-index field set.
    function automatic logic addr_fault(input logic [31:0] a);
        logic [31:0] hi;
        hi = a >> (ADDR_W + 2);
        return (a[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

    function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] a);
        return a[ADDR_W+1:2];
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_next_s;

    logic                we_r;
    logic [ADDR_W-1:0]   idx_r;
    logic [31:0]         wdata_r;
    logic                fault_r;

    logic                ack_r;
    logic                err_r;
    logic [31:0]         rdata_r;
    logic                busy_r;
    logic                ack_next_s;
    logic                err_next_s;
    logic [31:0]         rdata_next_s;
    logic                busy_next_s;

    logic                capture_s;
    logic                commit_s;
    logic                cur_we_s;
    logic [ADDR_W-1:0]   cur_idx_s;
    logic [31:0]         cur_wdata_s;
    logic                cur_fault_s;
    logic                mem_we_s;

    logic [31:0]         mem_r [0:DEPTH-1];

    // With zero wait states the access commits on the capture edge, so it
    // must use the live request fields rather than the latched copies.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_we_s    = bus.we;
            cur_idx_s   = word_index(bus.addr);
            cur_wdata_s = bus.wdata;
            cur_fault_s = addr_fault(bus.addr);
        end else begin
            cur_we_s    = we_r;
            cur_idx_s   = idx_r;
            cur_wdata_s = wdata_r;
            cur_fault_s = fault_r;
        end
    end

    // Next-state, wait counter and registered-output next values.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        capture_s    = 1'b0;
        commit_s     = 1'b0;
        ack_next_s   = 1'b0;
        err_next_s   = 1'b0;
        rdata_next_s = rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    capture_s = 1'b1;
                    if (HAS_WAIT) begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = WAIT_INIT;
                    end else begin
                        state_next_s = ST_RESP;
                        commit_s     = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                    commit_s     = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase

        if (commit_s) begin
            ack_next_s = 1'b1;
            err_next_s = cur_fault_s;
            if (cur_fault_s) begin
                rdata_next_s = 32'h0000_0000;
            end else if (!cur_we_s) begin
                rdata_next_s = mem_r[cur_idx_s];
            end else begin
                rdata_next_s = rdata_r;
            end
        end else begin
            ack_next_s = 1'b0;
        end

        busy_next_s = (state_next_s != ST_IDLE);
        mem_we_s    = commit_s & cur_we_s & ~cur_fault_s;
    end

    // State, counter, request latch and registered outputs; reset aborts any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            idx_r   <= '0;
            wdata_r <= 32'd0;
            fault_r <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (capture_s) begin
                we_r    <= bus.we;
                idx_r   <= word_index(bus.addr);
                wdata_r <= bus.wdata;
                fault_r <= addr_fault(bus.addr);
            end
            ack_r   <= ack_next_s;
            err_r   <= err_next_s;
            rdata_r <= rdata_next_s;
            busy_r  <= busy_next_s;
        end
    end

    // Word storage; contents survive reset, and a reset edge drops the write.
    always_ff @(posedge clk) begin
        if (rst && mem_we_s) begin
            mem_r[cur_idx_s] <= cur_wdata_s;
        end
    end

    assign bus.ack   = ack_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_CYCLES=2 instance for access/fault/reset
// behaviour and a WAIT_CYCLES=0 instance for back-to-back requests with req held.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt    = 0;
    int   miscmp_cnt = 0;

    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder_if bus0 ();

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One single access on the WAIT_CYCLES=2 instance; inputs are scrambled after capture.
    task automatic do_access(input string tag, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rdata,
                             input logic exp_err);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1;
        bus.req = 1'b0; bus.we = ~w; bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'hDEAD_BEEF;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) check_vec({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            if (bus.ack === 1'b1) begin
                lat = n;
                break;
            end
        end
        check_vec({tag, "_lat"}, lat, 32'd3);
        check_vec({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
        check_vec({tag, "_rdata"}, bus.rdata, exp_rdata);
        @(negedge clk);
        check_vec({tag, "_ackdrop"}, {30'd0, bus.ack, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = 32'd0;  bus.wdata = 32'd0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0;

        // Reset held two edges with req asserted
        rst = 1'b0;
        bus.req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("rst_ack",   {31'd0, bus.ack},  32'd0);
        check_vec("rst_err",   {31'd0, bus.err},  32'd0);
        check_vec("rst_rdata", bus.rdata,         32'd0);
        check_vec("rst_busy",  {31'd0, bus.busy}, 32'd0);
        bus.req = 1'b0;
        rst = 1'b1;

        // Write then read back; rdata after a write keeps its prior value
        do_access("wr10", 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0);
        do_access("rd10", 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0);

        // Misaligned read faults and returns zero; word intact
        do_access("rd13", 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1);
        do_access("rd10b", 1'b0, 32'h0000_0010, 32'h0,        32'h1234_5678, 1'b0);

        // Out-of-range write must not alias onto word 0
        do_access("wr00", 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h1234_5678, 1'b0);
        do_access("wr400", 1'b1, 32'h0000_0400, 32'h5555_5555, 32'h0000_0000, 1'b1);
        do_access("rd00", 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0);
        do_access("rdhi", 1'b0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1);

        // Reset during WAIT of a write aborts it
        do_access("wr20", 1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 32'h0000_0000, 1'b0);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0000_0020; bus.wdata = 32'h5555_5555;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        check_vec("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_vec("abort_busy", {31'd0, bus.busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_vec("abort_noack", {31'd0, bus.ack}, 32'd0);
            @(negedge clk);
        end
        do_access("rd20", 1'b0, 32'h0000_0020, 32'h0, 32'hAAAA_AAAA, 1'b0);

        // WAIT_CYCLES=0 with req held: write 0, write 4, read 0, read 4
        begin
            logic        rq_we [0:3];
            logic [31:0] rq_ad [0:3];
            logic [31:0] rq_wd [0:3];
            logic [31:0] rq_rd [0:3];
            int          r;
            rq_we[0] = 1'b1; rq_ad[0] = 32'h0; rq_wd[0] = 32'h0BAD_F00D; rq_rd[0] = 32'h0;
            rq_we[1] = 1'b1; rq_ad[1] = 32'h4; rq_wd[1] = 32'h1357_9BDF; rq_rd[1] = 32'h0;
            rq_we[2] = 1'b0; rq_ad[2] = 32'h0; rq_wd[2] = 32'h0;         rq_rd[2] = 32'h0BAD_F00D;
            rq_we[3] = 1'b0; rq_ad[3] = 32'h4; rq_wd[3] = 32'h0;         rq_rd[3] = 32'h1357_9BDF;
            @(negedge clk);
            bus0.req = 1'b1; bus0.we = rq_we[0]; bus0.addr = rq_ad[0]; bus0.wdata = rq_wd[0];
            @(posedge clk);
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                if ((k % 2 == 1) && (k <= 7)) begin
                    r = (k - 1) / 2;
                    check_vec("b2b_ack", {31'd0, bus0.ack}, 32'd1);
                    check_vec("b2b_err", {31'd0, bus0.err}, 32'd0);
                    if (!rq_we[r]) check_vec("b2b_rdata", bus0.rdata, rq_rd[r]);
                    if (r < 3) begin
                        bus0.we = rq_we[r+1]; bus0.addr = rq_ad[r+1]; bus0.wdata = rq_wd[r+1];
                    end else begin
                        bus0.req = 1'b0;
                    end
                end else begin
                    check_vec("b2b_noack", {31'd0, bus0.ack}, 32'd0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
